servo_speed_control: RTL and testbench
======================================

# servo_speed_control

Speed-limited servo position ramp generator. On a `go` pulse it latches a start position, end position and prescale value, then moves its position output one count at a time from start toward end, one step every `prescale+1` clocks. It sits between the motion command logic and the servo PWM generator, whose duty input is driven by `pos`.

## Interface
- `WIDTH`, 16, width of the positions, the prescale value and the internal tick counter.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start_pos`  in  WIDTH  unsigned initial position; sampled only on an accepted `go`.
- `end_pos`  in  WIDTH  unsigned target position; sampled only on an accepted `go`.
- `prescale`  in  WIDTH  unsigned; the step period is `prescale+1` clocks. Sampled only on an accepted `go`.
- `go`  in  1  start request, level-sampled each clock.
- `pos`  out  WIDTH  current commanded position; registered.
- `busy`  out  1  high while a ramp is in progress.
- `done`  out  1  one-clock pulse when `pos` reaches the target.

## Operation
- States are IDLE and RAMP.
- Reset values: state IDLE, `pos`=0, `busy`=0, `done`=0, tick counter 0, latched registers 0.
- **IDLE**
  - `go`=0: hold `pos`.
  - `go`=1: latch `end_pos` and `prescale`, load `pos`<=`start_pos`, clear the tick counter.
  - If `start_pos`==`end_pos`: stay in IDLE, pulse `done` on that edge, keep `busy`=0.
  - Otherwise: enter RAMP with `busy`=1.
- **RAMP**
  - The tick counter increments each clock.
  - When the counter equals the latched prescale, it returns to 0 and `pos` moves one count toward the latched end (+1 if end>pos, -1 if end<pos).
  - On the edge where the step makes `pos`==end: go to IDLE, set `busy`=0, pulse `done`=1 for exactly one clock.
- `go` while in RAMP is ignored. Input changes during a ramp have no effect.
- Direction is fixed by the comparison and both directions are supported. Arithmetic is unsigned. `pos` never leaves the closed range between start and end, so no wrap-around is possible.
- `prescale`=0 steps every clock.
- `go` held high after completion starts a new ramp on the next clock it is sampled in IDLE.
- `rst` asserted mid-ramp: immediately return to reset values; there is no resume.

## Timing
- Let T0 be the edge that samples `go`=1 in IDLE.
- At T0: `pos`=start_pos and `busy`=1.
- The first step lands at edge T0+(prescale+1).
- The k-th step lands at T0+k·(prescale+1).
- Final step at T0+N·(prescale+1), where N=|end−start|. On that same edge `pos`=end, `busy` falls and `done` rises. `done` clears on the next edge.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `servo_pkg`: state typedef (IDLE, RAMP) and the default `WIDTH` constant.
- One sub-module, `servo_step_prescaler`:
  - Loadable counter with clear and enable.
  - Emits a one-clock `tick` when count==prescale, then wraps to 0.
- The top level holds the FSM, the latched registers and the position up/down stepping.

## Test plan
- start=50, end=127, prescale=5, `go` pulsed for 1 clock → `pos`=50 at T0, 51 at T0+6, 127 at T0+462. `done` is high only during T0+462..T0+463. `busy` is high from T0 to T0+462.
- start=127, end=50, prescale=0 → `pos` decrements every clock and reaches 50 at T0+77 with a single `done` pulse.
- start=end=200 → `pos`=200 at T0, `done` pulse on the same edge, `busy` never asserts.
- Mid-ramp `go` pulse plus changed `end_pos`/`prescale` → no effect; the original ramp finishes at its original time.
- `rst` asserted asynchronously at T0+100 of the first scenario → `pos`=0, `busy`=0 and `done`=0 immediately. A new `go` after release restarts cleanly from start_pos.

Source files
------------

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the servo position ramp generator.
//   SERVO_WIDTH   : default width of positions, prescale and tick counter
//   servo_state_e : ramp controller states (IDLE, RAMP)
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int SERVO_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } servo_state_e;

endpackage : servo_pkg

// File: rtl/servo_step_prescaler.sv
// -----------------------------------------------------------------------------
// servo_step_prescaler
// Loadable step-rate counter. While enabled it counts 0..prescale and emits a
// one-clock tick on the clock where count==prescale, wrapping to 0 on that edge.
// Ports:
//   clk      in           system clock
//   rst      in           asynchronous active-high reset
//   clear    in           synchronous clear of the count (wins over enable)
//   enable   in           advance the count this clock
//   prescale in  [WIDTH]  terminal count; period is prescale+1 clocks
//   tick     out          high while enabled and count==prescale
// -----------------------------------------------------------------------------
module servo_step_prescaler
  import servo_pkg::*;
#(
  parameter int WIDTH = SERVO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic             at_term_s;

  assign at_term_s = (count_r == prescale);
  assign tick      = enable & at_term_s;

  // Tick counter: clear, wrap at terminal count, or count up while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO_C;
    end else if (clear) begin
      count_r <= ZERO_C;
    end else if (enable) begin
      if (at_term_s) begin
        count_r <= ZERO_C;
      end else begin
        count_r <= count_r + ONE_C;
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule : servo_step_prescaler

// File: rtl/servo_speed_control.sv
// -----------------------------------------------------------------------------
// servo_speed_control
// Speed-limited servo position ramp. An accepted go in IDLE latches the target
// and prescale, loads pos with start_pos and then moves pos one count toward
// the target every prescale+1 clocks. All outputs are registered.
// Ports:
//   clk       in           system clock
//   rst       in           asynchronous active-high reset
//   start_pos in  [WIDTH]  initial position, sampled on accepted go
//   end_pos   in  [WIDTH]  target position, sampled on accepted go
//   prescale  in  [WIDTH]  step period minus one, sampled on accepted go
//   go        in           start request, ignored while a ramp runs
//   pos       out [WIDTH]  commanded position (drives PWM duty)
//   busy      out          ramp in progress
//   done      out          one-clock pulse when pos reaches the target
// -----------------------------------------------------------------------------
module servo_speed_control
  import servo_pkg::*;
#(
  parameter int WIDTH = SERVO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] start_pos,
  input  logic [WIDTH-1:0] end_pos,
  input  logic [WIDTH-1:0] prescale,
  input  logic             go,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  servo_state_e     state_r;
  servo_state_e     next_state_s;
  logic [WIDTH-1:0] pos_r;
  logic [WIDTH-1:0] pos_next_s;
  logic [WIDTH-1:0] end_r;
  logic [WIDTH-1:0] end_next_s;
  logic [WIDTH-1:0] presc_r;
  logic [WIDTH-1:0] presc_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             clear_s;
  logic             enable_s;
  logic             tick_s;
  logic [WIDTH-1:0] step_pos_s;

  // The counter is cleared on an accepted go so the first step lands exactly
  // prescale+1 clocks after the go edge.
  servo_step_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .enable   (enable_s),
    .prescale (presc_r),
    .tick     (tick_s)
  );

  assign enable_s = (state_r == RAMP);

  // Candidate position one count toward the latched target; direction is
  // re-derived each step, and pos stays within [start, end] so no wrap occurs.
  always_comb begin
    step_pos_s = pos_r;
    if (end_r > pos_r) begin
      step_pos_s = pos_r + ONE_C;
    end else begin
      step_pos_s = pos_r - ONE_C;
    end
  end

  // Next-state and next-output logic for the IDLE/RAMP controller.
  always_comb begin
    next_state_s = state_r;
    pos_next_s   = pos_r;
    end_next_s   = end_r;
    presc_next_s = presc_r;
    busy_next_s  = busy_r;
    done_next_s  = 1'b0;
    clear_s      = 1'b0;
    case (state_r)
      IDLE: begin
        busy_next_s = 1'b0;
        if (go) begin
          end_next_s   = end_pos;
          presc_next_s = prescale;
          pos_next_s   = start_pos;
          clear_s      = 1'b1;
          if (start_pos == end_pos) begin
            done_next_s = 1'b1;
          end else begin
            next_state_s = RAMP;
            busy_next_s  = 1'b1;
          end
        end else begin
          pos_next_s = pos_r;
        end
      end
      RAMP: begin
        if (tick_s) begin
          pos_next_s = step_pos_s;
          if (step_pos_s == end_r) begin
            next_state_s = IDLE;
            busy_next_s  = 1'b0;
            done_next_s  = 1'b1;
          end else begin
            busy_next_s = 1'b1;
          end
        end else begin
          busy_next_s = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // State, latched command and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pos_r   <= ZERO_C;
      end_r   <= ZERO_C;
      presc_r <= ZERO_C;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      pos_r   <= pos_next_s;
      end_r   <= end_next_s;
      presc_r <= presc_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  assign pos  = pos_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule : servo_speed_control

// File: tb/tb_servo_speed_control.sv
// -----------------------------------------------------------------------------
// tb_servo_speed_control
// Directed bench for servo_speed_control. Edges are counted relative to T0
// (the edge that samples go=1 in IDLE); outputs are sampled 1ns after edges.
// -----------------------------------------------------------------------------
module tb_servo_speed_control;

  logic        clk;
  logic        rst;
  logic [15:0] start_pos;
  logic [15:0] end_pos;
  logic [15:0] prescale;
  logic        go;
  logic [15:0] pos;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int cyc;

  servo_speed_control #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_pos (start_pos),
    .end_pos   (end_pos),
    .prescale  (prescale),
    .go        (go),
    .pos       (pos),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] p, input logic b, input logic d);
    check({tag, ".pos"}, pos, p);
    check({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
    check({tag, ".done"}, {15'd0, done}, {15'd0, d});
  endtask

  // Advance one edge and sample 1ns after it.
  task automatic edge1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to edge T0+target.
  task automatic to_edge(input int target);
    while (cyc < target) edge1();
  endtask

  // Apply a command and take the T0 edge.
  task automatic launch(input logic [15:0] s, input logic [15:0] e, input logic [15:0] p);
    start_pos = s;
    end_pos   = e;
    prescale  = p;
    go        = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    start_pos = 16'd0;
    end_pos   = 16'd0;
    prescale  = 16'd0;
    go        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("idle_after_reset", 16'd0, 1'b0, 1'b0);

    // Up ramp 50->127, prescale 5, with an ignored mid-ramp go + new inputs
    launch(16'd50, 16'd127, 16'd5);
    go = 1'b0;
    check_out("up_t0", 16'd50, 1'b1, 1'b0);
    to_edge(5);
    check_out("up_t5", 16'd50, 1'b1, 1'b0);
    to_edge(6);
    check_out("up_t6", 16'd51, 1'b1, 1'b0);
    to_edge(99);
    start_pos = 16'd3;
    end_pos   = 16'd10;
    prescale  = 16'd0;
    go        = 1'b1;
    edge1();
    go = 1'b0;
    check_out("up_t100_ignored_go", 16'd66, 1'b1, 1'b0);
    to_edge(461);
    check_out("up_t461", 16'd126, 1'b1, 1'b0);
    to_edge(462);
    check_out("up_t462", 16'd127, 1'b0, 1'b1);
    to_edge(463);
    check_out("up_t463", 16'd127, 1'b0, 1'b0);

    // Down ramp 127->50, prescale 0: one count per clock, single done pulse
    launch(16'd127, 16'd50, 16'd0);
    go = 1'b0;
    check_out("down_t0", 16'd127, 1'b1, 1'b0);
    for (int k = 1; k <= 78; k++) begin
      edge1();
      if (k <= 77) begin
        check("down_pos", pos, 16'(127 - k));
      end else begin
        check("down_pos_hold", pos, 16'd50);
      end
      check("down_done", {15'd0, done}, {15'd0, (k == 77)});
      check("down_busy", {15'd0, busy}, {15'd0, (k < 77)});
    end

    // start == end: immediate done, busy never rises
    launch(16'd200, 16'd200, 16'd3);
    go = 1'b0;
    check_out("equal_t0", 16'd200, 1'b0, 1'b1);
    edge1();
    check_out("equal_t1", 16'd200, 1'b0, 1'b0);

    // go held high across completion restarts on the next IDLE clock
    launch(16'd10, 16'd12, 16'd1);
    check_out("held_t0", 16'd10, 1'b1, 1'b0);
    to_edge(2);
    check_out("held_t2", 16'd11, 1'b1, 1'b0);
    to_edge(4);
    check_out("held_t4", 16'd12, 1'b0, 1'b1);
    to_edge(5);
    go = 1'b0;
    check_out("held_t5_restart", 16'd10, 1'b1, 1'b0);
    to_edge(9);
    check_out("held_t9", 16'd12, 1'b0, 1'b1);

    // Asynchronous reset mid-ramp, then clean restart
    launch(16'd50, 16'd127, 16'd5);
    go = 1'b0;
    to_edge(100);
    check_out("rst_pre", 16'd66, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_async", 16'd0, 1'b0, 1'b0);
    edge1();
    check_out("rst_held", 16'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    edge1();
    check_out("rst_released", 16'd0, 1'b0, 1'b0);
    launch(16'd50, 16'd127, 16'd5);
    go = 1'b0;
    check_out("restart_t0", 16'd50, 1'b1, 1'b0);
    to_edge(6);
    check_out("restart_t6", 16'd51, 1'b1, 1'b0);
    to_edge(462);
    check_out("restart_t462", 16'd127, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_servo_speed_control
